aes_enc_iter: RTL
=================

# aes_enc_iter

Iterative AES-128 encryption core: one plaintext block and one 128-bit cipher key per transaction, ten rounds computed one per clock, with on-the-fly key expansion. It is the forward counterpart of the decrypt path built from `inv_shift_rows`/`inv_sub_bytes`/`inv_mix_columns`. It reuses the forward round primitives `sub_bytes`, `shift_rows` and `mix_columns`, plus four S-box lookups for the key schedule. The ciphertext it produces is the input for decrypt-path round-trip testing.

## Interface
- No parameters; block size and key size are fixed at 128 bits.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  plaintext and key are presented.
- `in_ready`  out  1  core can accept a block.
- `plaintext`  in  128  input block. Byte 0 is bits [127:120]; bytes are column-major per FIPS-197.
- `key`  in  128  cipher key, same byte order as `plaintext`.
- `out_valid`  out  1  `ciphertext` holds a result.
- `out_ready`  in  1  downstream accepts the result.
- `ciphertext`  out  128  encrypted block, same byte order.

## Operation
- Input handshake: `in_valid & in_ready` on a rising edge. Output handshake: `out_valid & out_ready` on a rising edge.
- FSM states:
  - IDLE: `in_ready`=1.
  - BUSY: rounds in progress.
  - DONE: `out_valid`=1.
- IDLE→BUSY on input handshake. In that edge:
  - state_reg ← `plaintext ^ key` (AddRoundKey, round 0).
  - key_reg ← `key`.
  - rcon ← 8'h01.
  - round ← 1.
- BUSY, each edge:
  - next round key is computed from key_reg and rcon: RotWord, SubWord, XOR rcon into the MSB byte, then the cascaded word XORs.
  - rounds 1–9: state_reg ← MixColumns(ShiftRows(SubBytes(state))) ^ next round key.
  - round 10: MixColumns is skipped.
  - key_reg ← next round key.
  - rcon ← xtime(rcon): multiply by 2 in GF(2^8), reduce by 8'h1b on carry. Sequence is 01,02,04,08,10,20,40,80,1b,36.
  - round increments.
- BUSY→DONE on the edge that completes round 10.
- DONE holds `ciphertext` = state_reg stable until the output handshake, then goes to IDLE.
- `in_ready` = (state==IDLE). There is no overlap: a new block is not accepted in the same cycle as the output handshake.
- `plaintext`/`key` are sampled only at the input handshake. Changes while in BUSY or DONE are ignored.
- `out_ready` is ignored outside DONE.
- `round` is 4 bits, valid values 1..10. Values 0 and 11–15 are unreachable. If reached, the FSM returns to IDLE on the next edge.
- All XORs are 128-bit bitwise. There is no carry arithmetic outside xtime.

## Timing
- Reset (async assert, sync to `clk` on deassert) sets:
  - state = IDLE, `in_ready`=1, `out_valid`=0.
  - `ciphertext`=0, round=0, rcon=0, key_reg=0.
- Latency:
  - input handshake at edge T; `out_valid` rises after edge T+10.
  - earliest output handshake at edge T+11.
  - earliest next input handshake at edge T+12.
  - throughput is 1 block / 12 cycles with `out_ready` tied high.
- Backpressure: with `out_ready`=0, DONE persists indefinitely with `ciphertext` unchanged.
- Reset mid-operation (BUSY or DONE): the in-flight block is discarded and all outputs return to reset values immediately, without waiting for a clock edge.
- `in_valid` asserted during BUSY/DONE does not complete a handshake and does not disturb the computation.
- `ciphertext` changes only on the edge that completes round 10; between that edge and the output handshake it is glitch-free.

## Test plan
- FIPS-197 App. C.1:
  - key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - `out_valid` rises exactly 10 cycles after acceptance.
- FIPS-197 App. B:
  - key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32.
  - after round 1 of this vector, internal state = a49c7ff2689f352b6b5bea43026a5049.
- Backpressure:
  - hold `out_ready`=0 for 20 cycles after DONE → `ciphertext` stable, `in_ready`=0 throughout.
  - raising `out_ready` → one handshake, then `in_ready`=1 on the next cycle.
- Input ignored while busy: change `plaintext`/`key` to all-ones with `in_valid`=1 during round 5 → result still matches the original vector, and no second transaction occurs.
- Reset mid-operation: assert `rst_n`=0 during round 6 → outputs immediately take reset values. A subsequent App. C.1 transaction completes correctly.
- Back-to-back and round-trip:
  - three blocks with `out_ready`=1 → each result matches a golden model, with 12-cycle spacing between acceptances.
  - feeding each ciphertext to the decrypt path recovers the plaintext.

Source files
------------

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key expansion.
// A block is accepted in IDLE, runs rounds 1..10 in BUSY and is held in DONE until it is taken.
module aes_enc_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Byte 4c+r sits at row r, column c; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r] = s[127 - 8*(4*c + r) -: 8];
            end
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = xtime(a[r]) ^ xtime(a[(r + 1) % 4]) ^ a[(r + 1) % 4]
                                          ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    fsm_e         fsm_r;
    logic [127:0] data_r;
    logic [127:0] key_r;
    logic [7:0]   rcon_r;
    logic [3:0]   round_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic [127:0] ciphertext_r;

    logic [127:0] shifted_s;
    logic [127:0] round_key_s;
    logic [127:0] round_out_s;
    logic         round_ok_s;

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign ciphertext = ciphertext_r;

    // One encryption round and the matching key-schedule step.
    always_comb begin
        shifted_s   = shift_rows(sub_bytes(data_r));
        round_key_s = next_key(key_r, rcon_r);
        round_ok_s  = (round_r >= 4'd1) && (round_r <= 4'd10);
        if (round_r == 4'd10) begin
            round_out_s = shifted_s ^ round_key_s;
        end else begin
            round_out_s = mix_columns(shifted_s) ^ round_key_s;
        end
    end

    // Control FSM and round datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r        <= IDLE;
            data_r       <= 128'd0;
            key_r        <= 128'd0;
            rcon_r       <= 8'h00;
            round_r      <= 4'd0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            ciphertext_r <= 128'd0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        data_r     <= plaintext ^ key;
                        key_r      <= key;
                        rcon_r     <= 8'h01;
                        round_r    <= 4'd1;
                        in_ready_r <= 1'b0;
                        fsm_r      <= BUSY;
                    end
                end
                BUSY: begin
                    if (!round_ok_s) begin
                        // Corrupted round counter: abandon the block.
                        round_r    <= 4'd0;
                        in_ready_r <= 1'b1;
                        fsm_r      <= IDLE;
                    end else begin
                        data_r <= round_out_s;
                        key_r  <= round_key_s;
                        rcon_r <= xtime(rcon_r);
                        if (round_r == 4'd10) begin
                            ciphertext_r <= round_out_s;
                            out_valid_r  <= 1'b1;
                            fsm_r        <= DONE;
                        end else begin
                            round_r <= round_r + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        fsm_r       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    round_r     <= 4'd0;
                    fsm_r       <= IDLE;
                end
            endcase
        end
    end

endmodule
